// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter and its register scoreboard.
// Covers the arbiter state encoding and the register-file geometry.
package writeback_arbiter_pkg;

    localparam int REG_IDX_W = 5;
    localparam int REG_COUNT = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [0:0] {
        PIPE_PRIO = 1'b0,
        MD_FORCE  = 1'b1
    } wb_state_t;

    // x0 is hardwired to zero: never written, never pending, never busy.
    function automatic logic is_x0(input reg_idx_t idx);
        return idx == '0;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Outstanding mul/div destination tracker plus operand busy lookup for decode.
// A register is busy while its result is pending or is being written this cycle.
module wb_scoreboard
    import writeback_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_rd,
    output logic                 issue_ready,
    input  logic                 clr_valid,
    input  logic [REG_IDX_W-1:0] clr_rd,
    input  logic                 rf_we,
    input  logic [REG_IDX_W-1:0] rf_waddr,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 busy_rs1,
    output logic                 busy_rs2
);

    logic [REG_COUNT-1:0] pending_reg;
    logic [REG_COUNT-1:0] pending_next;
    logic                 issue_accept;

    // Acceptance looks at the pre-edge mask, so a same-cycle clear never
    // lets a second op to the same register slip in.
    assign issue_ready  = !pending_reg[issue_rd];
    assign issue_accept = issue_valid && issue_ready && !is_x0(issue_rd);

    genvar gi;
    generate
        for (gi = 0; gi < REG_COUNT; gi++) begin : g_bit
            if (gi == 0) begin : g_x0
                assign pending_next[gi] = 1'b0;
            end else begin : g_reg
                localparam logic [REG_IDX_W-1:0] IDX = REG_IDX_W'(gi);
                logic set_hit;
                logic clr_hit;
                assign set_hit = issue_accept && (issue_rd == IDX);
                assign clr_hit = clr_valid && (clr_rd == IDX);
                assign pending_next[gi] = set_hit ? 1'b1 :
                                          clr_hit ? 1'b0 : pending_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign busy_rs1 = pending_reg[rs1] | (rf_we && (rf_waddr == rs1) && !is_x0(rs1));
    assign busy_rs2 = pending_reg[rs2] | (rf_we && (rf_waddr == rs2) && !is_x0(rs2));

endmodule

// File: rtl/writeback_arbiter.sv
// Single-port register-file writeback arbiter between the pipeline and a mul/div unit,
// with pipeline priority, starvation forcing for mul/div and a destination scoreboard.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int N            = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_rd,
    output logic                 issue_ready,
    input  logic                 pipe_valid,
    input  logic [REG_IDX_W-1:0] pipe_rd,
    input  logic [N-1:0]         pipe_data,
    output logic                 pipe_ready,
    input  logic                 md_valid,
    input  logic [REG_IDX_W-1:0] md_rd,
    input  logic [N-1:0]         md_data,
    output logic                 md_ready,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_waddr,
    output logic [N-1:0]         rf_wdata,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 busy_rs1,
    output logic                 busy_rs2
);

    localparam int               CNT_W   = 4;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    wb_state_t        state_reg;
    wb_state_t        state_next;
    wb_state_t        state_eff;
    logic [CNT_W-1:0] starve_reg;
    logic [CNT_W-1:0] starve_next;

    logic                 pipe_grant;
    logic                 md_grant;
    logic                 wr_en;
    logic [REG_IDX_W-1:0] wr_addr;
    logic [N-1:0]         wr_data;

    // While rst is held the ready outputs behave as in PIPE_PRIO, whatever
    // the state register happens to contain.
    assign state_eff = rst ? PIPE_PRIO : state_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= PIPE_PRIO;
            starve_reg <= '0;
        end else begin
            state_reg  <= state_next;
            starve_reg <= starve_next;
        end
    end

    always_comb begin
        starve_next = starve_reg;
        if (md_grant) begin
            starve_next = '0;
        end else if (md_valid && !md_ready && (starve_reg != LIMIT_C)) begin
            starve_next = starve_reg + CNT_W'(1);
        end
    end

    // Switching on the post-increment count puts the forced grant on the
    // cycle right after the limit-th blocked cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            PIPE_PRIO: if (!md_grant && (starve_next == LIMIT_C)) state_next = MD_FORCE;
            MD_FORCE:  if (md_grant) state_next = PIPE_PRIO;
            default:   state_next = PIPE_PRIO;
        endcase
    end

    always_comb begin
        pipe_ready = 1'b1;
        md_ready   = !pipe_valid;
        if (state_eff == MD_FORCE) begin
            pipe_ready = 1'b0;
            md_ready   = 1'b1;
        end
    end

    assign pipe_grant = pipe_valid && pipe_ready;
    assign md_grant   = md_valid && md_ready;

    // Grants are mutually exclusive by construction of the ready equations.
    assign wr_en   = (pipe_grant && !is_x0(pipe_rd)) || (md_grant && !is_x0(md_rd));
    assign wr_addr = md_grant ? md_rd   : pipe_rd;
    assign wr_data = md_grant ? md_data : pipe_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= wr_en;
            if (wr_en) begin
                rf_waddr <= wr_addr;
                rf_wdata <= wr_data;
            end
        end
    end

    wb_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .clr_valid   (md_grant),
        .clr_rd      (md_rd),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rs1         (rs1),
        .rs2         (rs2),
        .busy_rs1    (busy_rs1),
        .busy_rs2    (busy_rs2)
    );

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed scenarios plus randomized traffic for writeback_arbiter, checked
// against a cycle-level reference model of the grant, starvation and scoreboard rules.
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    localparam int N     = 32;
    localparam int LIMIT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         issue_valid;
    logic [4:0]   issue_rd;
    logic         issue_ready;
    logic         pipe_valid;
    logic [4:0]   pipe_rd;
    logic [N-1:0] pipe_data;
    logic         pipe_ready;
    logic         md_valid;
    logic [4:0]   md_rd;
    logic [N-1:0] md_data;
    logic         md_ready;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [N-1:0] rf_wdata;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic         busy_rs1;
    logic         busy_rs2;

    always #5 clk = ~clk;

    writeback_arbiter #(.N(N), .STARVE_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .pipe_valid  (pipe_valid),
        .pipe_rd     (pipe_rd),
        .pipe_data   (pipe_data),
        .pipe_ready  (pipe_ready),
        .md_valid    (md_valid),
        .md_rd       (md_rd),
        .md_data     (md_data),
        .md_ready    (md_ready),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .rs1         (rs1),
        .rs2         (rs2),
        .busy_rs1    (busy_rs1),
        .busy_rs2    (busy_rs2)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: set of outstanding destinations, length of the current
    // run of blocked mul/div cycles, and the write expected on the port.
    bit         m_pend [32];
    int         m_blocked = 0;
    bit         m_we      = 1'b0;
    logic [4:0] m_waddr   = '0;
    logic [31:0] m_wdata  = '0;

    logic obs_issue_ready, obs_pipe_ready, obs_md_ready, obs_busy1, obs_busy2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called just after a falling edge with inputs already applied; returns at
    // the next falling edge after checking the registered write port.
    task automatic eval_cycle();
        bit forced, e_pr, e_mr, e_ir, e_b1, e_b2, pg, mg, wr;
        #1;
        forced = !rst && (m_blocked >= LIMIT);
        e_pr   = !forced;
        e_mr   = forced || !pipe_valid;
        e_ir   = !m_pend[issue_rd];
        e_b1   = m_pend[rs1] || (m_we && m_waddr == rs1 && rs1 != 0);
        e_b2   = m_pend[rs2] || (m_we && m_waddr == rs2 && rs2 != 0);
        obs_issue_ready = issue_ready;
        obs_pipe_ready  = pipe_ready;
        obs_md_ready    = md_ready;
        obs_busy1       = busy_rs1;
        obs_busy2       = busy_rs2;
        chk("issue_ready", issue_ready, e_ir);
        chk("pipe_ready", pipe_ready, e_pr);
        chk("md_ready", md_ready, e_mr);
        chk("busy_rs1", busy_rs1, e_b1);
        chk("busy_rs2", busy_rs2, e_b2);
        chk("one_grant", pipe_valid && pipe_ready && md_valid && md_ready, 1'b0);
        pg = pipe_valid && e_pr;
        mg = md_valid && e_mr;
        if (rst) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_blocked = 0;
            m_we      = 1'b0;
            m_waddr   = '0;
            m_wdata   = '0;
        end else begin
            wr = 1'b0;
            if (pg && pipe_rd != 0) begin
                wr = 1'b1; m_waddr = pipe_rd; m_wdata = pipe_data;
            end
            if (mg && md_rd != 0) begin
                wr = 1'b1; m_waddr = md_rd; m_wdata = md_data;
            end
            m_we = wr;
            if (mg) m_blocked = 0;
            else if (md_valid && m_blocked < LIMIT) m_blocked++;
            if (mg) m_pend[md_rd] = 1'b0;
            if (issue_valid && e_ir && issue_rd != 0) m_pend[issue_rd] = 1'b1;
        end
        @(negedge clk);
        chk("rf_we", rf_we, m_we);
        chk("rf_waddr", rf_waddr, m_waddr);
        chk("rf_wdata", rf_wdata, m_wdata);
        if (rf_we) $display("wr x%0d <= %08h", rf_waddr, rf_wdata);
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_rd = '0;
        pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
        md_valid = 1'b0; md_rd = '0; md_data = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int cand[$];
        int r;
        rst = 1'b1; rs1 = '0; rs2 = '0;
        idle();
        repeat (2) @(negedge clk);
        eval_cycle();
        chk("rst_we", rf_we, 1'b0);
        chk("rst_waddr", rf_waddr, 5'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        rst = 1'b0;

        // Issue x5, mul/div result two cycles later, busy until the write retires.
        issue_valid = 1'b1; issue_rd = 5'd5; rs1 = 5'd5;
        eval_cycle();
        chk("t1_issue_ready", obs_issue_ready, 1'b1);
        idle();
        eval_cycle();
        chk("t1_busy_wait", obs_busy1, 1'b1);
        md_valid = 1'b1; md_rd = 5'd5; md_data = 32'hDEADBEEF;
        eval_cycle();
        chk("t1_md_ready", obs_md_ready, 1'b1);
        chk("t1_busy_grant", obs_busy1, 1'b1);
        chk("t1_we", rf_we, 1'b1);
        chk("t1_waddr", rf_waddr, 5'd5);
        chk("t1_wdata", rf_wdata, 32'hDEADBEEF);
        idle();
        eval_cycle();
        chk("t1_busy_wr", obs_busy1, 1'b1);
        eval_cycle();
        chk("t1_busy_done", obs_busy1, 1'b0);
        $display("txn: issue/md writeback x5 done");

        // Starvation: continuous pipe traffic blocks x7 result LIMIT cycles.
        issue_valid = 1'b1; issue_rd = 5'd7;
        eval_cycle();
        idle();
        pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h0000A5A5;
        md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h77777777;
        for (int k = 0; k < LIMIT; k++) begin
            eval_cycle();
            chk("t2_md_blocked", obs_md_ready, 1'b0);
            chk("t2_pipe_wins", obs_pipe_ready, 1'b1);
        end
        eval_cycle();
        chk("t2_md_forced", obs_md_ready, 1'b1);
        chk("t2_pipe_held", obs_pipe_ready, 1'b0);
        chk("t2_waddr", rf_waddr, 5'd7);
        md_valid = 1'b0;
        eval_cycle();
        chk("t2_pipe_resume", obs_pipe_ready, 1'b1);
        idle();
        eval_cycle();
        $display("txn: starvation force x7 done");

        // Re-issue to a pending register, including on its md grant cycle.
        issue_valid = 1'b1; issue_rd = 5'd3;
        eval_cycle();
        eval_cycle();
        chk("t3_pending", obs_issue_ready, 1'b0);
        md_valid = 1'b1; md_rd = 5'd3; md_data = 32'h33333333;
        eval_cycle();
        chk("t3_same_cycle", obs_issue_ready, 1'b0);
        chk("t3_md_ready", obs_md_ready, 1'b1);
        md_valid = 1'b0;
        eval_cycle();
        chk("t3_after", obs_issue_ready, 1'b1);
        idle();
        md_valid = 1'b1; md_rd = 5'd3; md_data = 32'h0BADF00D;
        eval_cycle();
        idle();
        $display("txn: reissue x3 done");

        // x0 writes and issues are accepted but invisible.
        pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h00001234;
        eval_cycle();
        chk("t4_pipe_ready", obs_pipe_ready, 1'b1);
        chk("t4_no_we", rf_we, 1'b0);
        idle();
        issue_valid = 1'b1; issue_rd = 5'd0; rs1 = 5'd0;
        eval_cycle();
        chk("t4_issue_x0", obs_issue_ready, 1'b1);
        idle();
        eval_cycle();
        chk("t4_busy_x0", obs_busy1, 1'b0);
        $display("txn: x0 handling done");

        // Reset with x9/x10 outstanding and a pipe request in the reset cycle.
        issue_valid = 1'b1; issue_rd = 5'd9;
        eval_cycle();
        issue_rd = 5'd10;
        eval_cycle();
        idle();
        rst = 1'b1; pipe_valid = 1'b1; pipe_rd = 5'd4; pipe_data = 32'h44444444;
        eval_cycle();
        chk("t5_rst_no_we", rf_we, 1'b0);
        rst = 1'b0; idle(); rs1 = 5'd9; rs2 = 5'd10;
        eval_cycle();
        chk("t5_busy9", obs_busy1, 1'b0);
        chk("t5_busy10", obs_busy2, 1'b0);
        chk("t5_pipe_prio", obs_pipe_ready, 1'b1);
        $display("txn: mid-operation reset done");

        // Randomized traffic with held requests and occasional resets.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!pipe_valid && $urandom_range(0, 9) < 6) begin
                r = $urandom_range(0, 31);
                if (m_pend[r]) r = 0;
                pipe_valid = 1'b1; pipe_rd = 5'(r); pipe_data = $urandom;
            end
            if (!md_valid && $urandom_range(0, 9) < 4) begin
                cand.delete();
                for (int i = 1; i < 32; i++) if (m_pend[i]) cand.push_back(i);
                if (cand.size() > 0) begin
                    md_valid = 1'b1;
                    md_rd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
                    md_data = $urandom;
                end
            end
            issue_valid = ($urandom_range(0, 9) < 3);
            issue_rd    = 5'($urandom_range(0, 31));
            rs1         = 5'($urandom_range(0, 31));
            rs2         = 5'($urandom_range(0, 31));
            eval_cycle();
            if (pipe_valid && obs_pipe_ready) pipe_valid = 1'b0;
            if (md_valid && obs_md_ready) md_valid = 1'b0;
            if (rst) idle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
